// File: rtl/vga_draw_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_draw_arbiter_if
//   Bundle between the puzzle's drawing engines and the VGA write-port
//   arbiter.
//   Engine side (master) drives:
//     req, done, plot_in           NREQ-bit per-engine request/completion/strobe
//     x_in, y_in, col_in           packed per-engine pixel data, engine i at [i*W +: W]
//   Arbiter side (slave) drives:
//     gnt                          one-hot registered grant
//     vga_x, vga_y, vga_col        pixel data muxed onto the adapter
//     vga_plot                     pixel write strobe to the adapter
//     busy, timeout                status: port granted / watchdog release pulse
// ---------------------------------------------------------------------------
interface vga_draw_arbiter_if #(
  parameter int NREQ = 4,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    plot_in;
  logic [NREQ*XW-1:0] x_in;
  logic [NREQ*YW-1:0] y_in;
  logic [NREQ*CW-1:0] col_in;
  logic [NREQ-1:0]    gnt;
  logic [XW-1:0]      vga_x;
  logic [YW-1:0]      vga_y;
  logic [CW-1:0]      vga_col;
  logic               vga_plot;
  logic               busy;
  logic               timeout;

  modport master (
    output req, done, plot_in, x_in, y_in, col_in,
    input  gnt, vga_x, vga_y, vga_col, vga_plot, busy, timeout
  );

  modport slave (
    input  req, done, plot_in, x_in, y_in, col_in,
    output gnt, vga_x, vga_y, vga_col, vga_plot, busy, timeout
  );
endinterface

// File: rtl/vga_draw_arbiter.sv
// ---------------------------------------------------------------------------
// vga_draw_arbiter
//   Shares the single VGA adapter write port between the drawing engines
//   (clear, grid, difficulty label, tile number). One engine is granted at a
//   time and its pixel stream is muxed onto the adapter until it signals done,
//   drops its request, or the watchdog reclaims the port.
//   Engine 0 (clear) has absolute priority at arbitration time; engines
//   1..NREQ-1 are served round-robin. A grant is never pre-empted.
// Ports
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    vga_draw_arbiter_if.slave (requests and pixel data in; grant,
//          muxed pixel stream and status out)
// ---------------------------------------------------------------------------
module vga_draw_arbiter #(
  parameter int NREQ    = 4,
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int CW      = 3,
  parameter int TIMEOUT = 40000
) (
  input  logic                clk,
  input  logic                reset,
  vga_draw_arbiter_if.slave   bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RELEASE
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic            timeout_q;
  logic [IW-1:0]   winner_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [WW-1:0]   wdog_q;
  logic [XW-1:0]   last_x_q;
  logic [YW-1:0]   last_y_q;
  logic [CW-1:0]   last_col_q;

  logic [IW-1:0]   pick_d;
  logic [IW-1:0]   rr_next_d;
  logic [XW-1:0]   mux_x;
  logic [YW-1:0]   mux_y;
  logic [CW-1:0]   mux_col;
  logic            rel_done;
  logic            rel_abort;
  logic            rel_wdog;

  // Winner selection. The round-robin scan runs from the far end back toward
  // rr_ptr so the last hit written is the one closest to rr_ptr.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    int idx;
    pick_d = '0;
    idx    = 0;
    if (!bus.req[0]) begin
      for (int k = NREQ - 2; k >= 0; k--) begin
        idx = ((int'(rr_ptr_q) - 1 + k) % (NREQ - 1)) + 1;
        if (bus.req[idx[IW-1:0]]) pick_d = idx[IW-1:0];
      end
    end
  end

  // Pointer advances past the winner, wrapping NREQ-1 -> 1; index 0 never
  // moves it.
  assign rr_next_d = (winner_q == IW'(NREQ - 1)) ? IW'(1) : winner_q + 1'b1;

  assign mux_x   = bus.x_in  [int'(winner_q)*XW +: XW];
  assign mux_y   = bus.y_in  [int'(winner_q)*YW +: YW];
  assign mux_col = bus.col_in[int'(winner_q)*CW +: CW];

  // Exit causes, in priority order; the watchdog only reports when neither
  // done nor abort applies in the same cycle.
  assign rel_done  = bus.done[winner_q];
  assign rel_abort = !bus.req[winner_q];
  assign rel_wdog  = (wdog_q == WW'(TIMEOUT - 1));

  // NOTE: sequential state is assigned with <= only, so every register here
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      winner_q   <= '0;
      rr_ptr_q   <= IW'(1);
      wdog_q     <= '0;
      // NOTE: the held pixel registers are reset too, because the adapter
      // must see x/y/col = 0 straight after reset, not stale data.
      last_x_q   <= '0;
      last_y_q   <= '0;
      last_col_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|bus.req) begin
            winner_q        <= pick_d;
            gnt_q           <= '0;
            gnt_q[pick_d]   <= 1'b1;
            busy_q          <= 1'b1;
            wdog_q          <= '0;
            state_q         <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Remember what was last presented so the adapter inputs stay
          // stable once the grant is gone.
          last_x_q   <= mux_x;
          last_y_q   <= mux_y;
          last_col_q <= mux_col;
          wdog_q     <= wdog_q + 1'b1;
          if (rel_done || rel_abort || rel_wdog) begin
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= !rel_done && !rel_abort;
            if (winner_q != '0) rr_ptr_q <= rr_next_d;
            state_q   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel data passes straight through while granted; only plot is gated off
  // outside BUSY, the coordinates hold their last forwarded value.
  assign bus.vga_x    = busy_q ? mux_x   : last_x_q;
  assign bus.vga_y    = busy_q ? mux_y   : last_y_q;
  assign bus.vga_col  = busy_q ? mux_col : last_col_q;
  assign bus.vga_plot = busy_q & bus.plot_in[winner_q];
  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_draw_arbiter
//   Directed bench for vga_draw_arbiter (NREQ=4, TIMEOUT=16). The stimulus
//   process queues the observation it expects at a given cycle; the monitor
//   samples on the falling edge and, whenever the DUT shows an event (grant
//   change, plot, timeout, or a cycle following a sampled reset), pops the
//   next expectation and compares it including the cycle number.
// ---------------------------------------------------------------------------
module tb_vga_draw_arbiter;

  localparam int NREQ = 4;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 3;

  typedef struct packed {
    int              at;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            plot;
    logic            tmo;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   col;
  } obs_t;

  logic clk;
  logic reset;
  int   cyc;
  logic rst_smp;
  int   n_checks;
  int   n_fail;
  obs_t exp_q[$];
  logic [NREQ-1:0] prev_gnt;

  // Per-engine pixel data driven for the whole run.
  int eng_x [NREQ] = '{10, 11, 12, 40};
  int eng_y [NREQ] = '{20, 21, 22, 23};
  int eng_c [NREQ] = '{1, 2, 3, 4};

  vga_draw_arbiter_if #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW)) bus ();

  vga_draw_arbiter #(
    .NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc      = 0;
    rst_smp  = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    prev_gnt = '0;
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= reset;
  end

  // ---------------- expectation helpers ----------------
  task automatic push(input int at, input logic [NREQ-1:0] g, input logic b,
                      input logic p, input logic t, input int eng, input logic zero);
    obs_t e;
    e.at   = at;
    e.gnt  = g;
    e.busy = b;
    e.plot = p;
    e.tmo  = t;
    e.x    = zero ? '0 : XW'(eng_x[eng]);
    e.y    = zero ? '0 : YW'(eng_y[eng]);
    e.col  = zero ? '0 : CW'(eng_c[eng]);
    exp_q.push_back(e);
  endtask

  task automatic push_busy(input int at, input int eng, input logic p);
    push(at, NREQ'(1) << eng, 1'b1, p, 1'b0, eng, 1'b0);
  endtask

  task automatic push_idle(input int at, input int eng, input logic t);
    push(at, '0, 1'b0, 1'b0, t, eng, 1'b0);
  endtask

  task automatic push_rst(input int at);
    push(at, '0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    if (rst_smp || (bus.gnt !== prev_gnt) || bus.vga_plot || bus.timeout) begin
      a.at   = cyc;
      a.gnt  = bus.gnt;
      a.busy = bus.busy;
      a.plot = bus.vga_plot;
      a.tmo  = bus.timeout;
      a.x    = bus.vga_x;
      a.y    = bus.vga_y;
      a.col  = bus.vga_col;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got cyc=%0d gnt=%b busy=%b plot=%b tmo=%b x=%0d y=%0d col=%0d, none expected",
                 a.at, a.gnt, a.busy, a.plot, a.tmo, a.x, a.y, a.col);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL event_at_cyc%0d: got cyc=%0d gnt=%b busy=%b plot=%b tmo=%b x=%0d y=%0d col=%0d, want cyc=%0d gnt=%b busy=%b plot=%b tmo=%b x=%0d y=%0d col=%0d",
                   e.at, a.at, a.gnt, a.busy, a.plot, a.tmo, a.x, a.y, a.col,
                   e.at, e.gnt, e.busy, e.plot, e.tmo, e.x, e.y, e.col);
        end
      end
    end
    prev_gnt = bus.gnt;
  end

  // ---------------- stimulus ----------------
  initial begin
    obs_t e;
    bus.req     = '0;
    bus.done    = '0;
    bus.plot_in = '0;
    bus.x_in    = {8'd40, 8'd12, 8'd11, 8'd10};
    bus.y_in    = {7'd23, 7'd22, 7'd21, 7'd20};
    bus.col_in  = {3'd4, 3'd3, 3'd2, 3'd1};

    // 1. Reset held with every engine requesting: nothing granted, then the
    //    clear engine wins one cycle after reset drops.
    reset   = 1'b1;
    bus.req = 4'b1111;
    push_rst(1);
    push_rst(2);
    push_rst(3);
    repeat (3) tick();
    reset = 1'b0;
    push_busy(cyc + 1, 0, 1'b0);
    tick();
    bus.req  = '0;
    bus.done = 4'b0001;
    push_idle(cyc + 1, 0, 1'b0);
    tick();
    bus.done = '0;
    tick();                                   // RELEASE -> IDLE

    // 2. rr_ptr=1: engine 1 first, engine 2 after two gnt=0 cycles.
    bus.req = 4'b0110;
    push_busy(cyc + 1, 1, 1'b0);
    tick();
    bus.done = 4'b0010;
    bus.req  = 4'b0100;
    push_idle(cyc + 1, 1, 1'b0);
    push_busy(cyc + 3, 2, 1'b0);
    tick();
    bus.done = '0;
    repeat (2) tick();

    // 3. req[0] rising mid-grant does not pre-empt engine 2.
    bus.req = 4'b0101;
    repeat (2) tick();
    bus.done = 4'b0100;
    bus.req  = 4'b0001;
    push_idle(cyc + 1, 2, 1'b0);
    push_busy(cyc + 3, 0, 1'b0);
    tick();
    bus.done = '0;
    repeat (2) tick();
    bus.done = 4'b0001;
    bus.req  = '0;
    push_idle(cyc + 1, 0, 1'b0);
    tick();
    bus.done = '0;
    tick();

    // 4. Engine 3 granted (rr_ptr=3); engine 0's plot is ignored, engine 3's
    //    plot and x=40 pass through, including in the done cycle.
    bus.req = 4'b1000;
    push_busy(cyc + 1, 3, 1'b0);
    tick();
    bus.plot_in = 4'b0001;
    tick();
    bus.plot_in = 4'b1001;
    push_busy(cyc, 3, 1'b1);
    tick();
    bus.done = 4'b1000;
    push_busy(cyc, 3, 1'b1);
    push_idle(cyc + 1, 3, 1'b0);
    tick();
    bus.done    = '0;
    bus.req     = '0;
    bus.plot_in = '0;
    tick();

    // 5. Watchdog: rr_ptr wrapped to 1, engine 1 never finishes; release
    //    after 16 BUSY cycles with a single-cycle timeout pulse.
    bus.req = 4'b0110;
    push_busy(cyc + 1, 1, 1'b0);
    push_idle(cyc + 17, 1, 1'b1);
    repeat (17) tick();
    bus.req = '0;
    tick();

    // 6. Reset mid-BUSY (engine 2 granted, rr_ptr=2): grant drops, rr_ptr
    //    returns to 1 so engine 1 wins next; then an abort exit.
    bus.req = 4'b0110;
    push_busy(cyc + 1, 2, 1'b0);
    tick();
    reset = 1'b1;
    push_rst(cyc + 1);
    tick();
    reset = 1'b0;
    push_busy(cyc + 1, 1, 1'b0);
    tick();
    bus.req = '0;
    push_idle(cyc + 1, 1, 1'b0);
    repeat (5) tick();

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_event: got nothing, want event at cyc=%0d gnt=%b tmo=%b",
               e.at, e.gnt, e.tmo);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of stimulus, want finish before 200000");
    $fatal(1, "bench time limit");
  end

endmodule
